// File: rtl/bus_forkjoin_hub_pkg.sv
// Shared types for the fork/join bus hub.
//   hub_state_e : top-level FSM states
//   hub_err_e   : response code returned to the master with m_rvalid
//   popcount32  : population count used for the multi-claim check
package bus_hub_pkg;

    typedef enum logic [1:0] {IDLE, FORK, JOIN, RESP} hub_state_e;

    typedef enum logic [1:0] {ERR_OK, ERR_DECERR, ERR_MULTIHIT, ERR_TIMEOUT} hub_err_e;

    // Slave count is capped so the hit mask always fits the popcount input.
    localparam int MAX_SLAVES = 32;

    function automatic int unsigned popcount32(input logic [MAX_SLAVES-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MAX_SLAVES; i++) c += 32'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/bus_forkjoin_hub_if.sv
// Master command bus plus the broadcast slave bus of the fork/join hub.
//   m_*  : master command (req/write/addr/wdata) and merged response
//          (ready/rvalid/rdata/err)
//   s_*  : forked command to all slaves and per-slave done/hit/rdata
// Modport slave is the hub's view (it is the slave of the master bus and
// the driver of the slave bus); modport master is the surrounding system.
interface bus_forkjoin_hub_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
);
    import bus_hub_pkg::*;

    logic                         m_req;
    logic                         m_write;
    logic [ADDR_W-1:0]            m_addr;
    logic [DATA_W-1:0]            m_wdata;
    logic                         m_ready;
    logic                         m_rvalid;
    logic [DATA_W-1:0]            m_rdata;
    hub_err_e                     m_err;

    logic [NUM_SLAVES-1:0]        s_req;
    logic                         s_write;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [NUM_SLAVES-1:0]        s_done;
    logic [NUM_SLAVES-1:0]        s_hit;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;

    modport slave (
        input  m_req, m_write, m_addr, m_wdata,
        output m_ready, m_rvalid, m_rdata, m_err,
        output s_req, s_write, s_addr, s_wdata,
        input  s_done, s_hit, s_rdata
    );

    modport master (
        output m_req, m_write, m_addr, m_wdata,
        input  m_ready, m_rvalid, m_rdata, m_err,
        input  s_req, s_write, s_addr, s_wdata,
        output s_done, s_hit, s_rdata
    );

endinterface

// File: rtl/bus_forkjoin_hub_tracker.sv
// Join bookkeeping for the hub: accumulates which slaves have finished and
// which claimed the address, and keeps the read data of the lowest-index
// slave from the first cycle in which any claim arrives.
//   clock, reset   : system clock, async active-high reset
//   clear          : wipe masks and captured data (held while hub is idle)
//   en             : hub is in JOIN; slave inputs are ignored otherwise
//   s_done/s_hit/s_rdata : raw slave completion bus
//   all_done       : every slave done, counting this cycle's s_done
//   hit_count_gt1  : more than one slave claimed the address
//   no_hit         : no slave claimed the address
//   rdata          : captured read data
module bus_join_tracker
    import bus_hub_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_W     = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         en,
    input  logic [NUM_SLAVES-1:0]        s_done,
    input  logic [NUM_SLAVES-1:0]        s_hit,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic                         all_done,
    output logic                         hit_count_gt1,
    output logic                         no_hit,
    output logic [DATA_W-1:0]            rdata
);

    logic [NUM_SLAVES-1:0] done_mask;
    logic [NUM_SLAVES-1:0] hit_mask;
    logic [NUM_SLAVES-1:0] new_done;
    logic [NUM_SLAVES-1:0] new_hit;
    logic [DATA_W-1:0]     sel_data;

    // A slave that already reported done cannot report again, so its
    // repeated hit/data are masked out here.
    assign new_done = en ? (s_done & ~done_mask) : '0;
    assign new_hit  = new_done & s_hit;
    assign all_done = en && ((done_mask | s_done) == '1);

    assign no_hit        = (hit_mask == '0);
    assign hit_count_gt1 = popcount32(MAX_SLAVES'(hit_mask)) > 1;

    // Walk from the top down so the lowest-index hitting slave wins.
    always_comb begin
        sel_data = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (new_hit[i]) sel_data = s_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_mask <= '0;
            hit_mask  <= '0;
            rdata     <= '0;
        end else if (clear) begin
            done_mask <= '0;
            hit_mask  <= '0;
            rdata     <= '0;
        end else if (en) begin
            done_mask <= done_mask | new_done;
            hit_mask  <= hit_mask | new_hit;
            // Capture only on the first cycle with any claim.
            if (hit_mask == '0 && new_hit != '0) rdata <= sel_data;
        end
    end

endmodule

// File: rtl/bus_forkjoin_hub.sv
// Fork/join dispatcher: accepts one master command, pulses it to every
// slave for one cycle, waits for all slaves to report done (or for the
// timeout), then returns a single merged response for one cycle.
//   clock, reset : system clock, async active-high reset
//   bus          : master command/response and broadcast slave bus
// Response codes: TIMEOUT > MULTIHIT > DECERR > OK. Read data is only
// returned for an OK read; everything else returns zero data.
module bus_forkjoin_hub
    import bus_hub_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic              clock,
    input  logic              reset,
    bus_forkjoin_hub_if.slave bus
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    hub_state_e        state, state_next;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TW-1:0]     timer;
    logic              timed_out;
    logic              timeout_hit;

    logic              all_done;
    logic              hit_count_gt1;
    logic              no_hit;
    logic [DATA_W-1:0] cap_data;
    hub_err_e          err_code;

    bus_join_tracker #(
        .NUM_SLAVES (NUM_SLAVES),
        .DATA_W     (DATA_W)
    ) u_tracker (
        .clock         (clock),
        .reset         (reset),
        .clear         (state == IDLE),
        .en            (state == JOIN),
        .s_done        (bus.s_done),
        .s_hit         (bus.s_hit),
        .s_rdata       (bus.s_rdata),
        .all_done      (all_done),
        .hit_count_gt1 (hit_count_gt1),
        .no_hit        (no_hit),
        .rdata         (cap_data)
    );

    assign timeout_hit = (TIMEOUT != 0) && (timer == TIMER_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.m_req) state_next = FORK;
            FORK: state_next = JOIN;
            // Completion is checked alongside the timeout; either exits.
            JOIN: if (all_done || timeout_hit) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            timer     <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer     <= '0;
                    timed_out <= 1'b0;
                    if (bus.m_req) begin
                        write_q <= bus.m_write;
                        addr_q  <= bus.m_addr;
                        wdata_q <= bus.m_wdata;
                    end
                end
                JOIN: begin
                    timer <= timer + TW'(1);
                    // A slave set that completes on the last allowed cycle
                    // is not a timeout.
                    if (timeout_hit && !all_done) timed_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        err_code = ERR_OK;
        if (timed_out)          err_code = ERR_TIMEOUT;
        else if (hit_count_gt1) err_code = ERR_MULTIHIT;
        else if (no_hit)        err_code = ERR_DECERR;
    end

    assign bus.m_ready  = (state == IDLE);
    assign bus.m_rvalid = (state == RESP);
    assign bus.m_err    = (state == RESP) ? err_code : ERR_OK;
    assign bus.m_rdata  = (state == RESP && err_code == ERR_OK && !write_q) ? cap_data : '0;

    assign bus.s_req    = {NUM_SLAVES{state == FORK}};
    assign bus.s_write  = write_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;

endmodule

// File: tb/tb_bus_forkjoin_hub.sv
// Directed bench for bus_forkjoin_hub. Instance u0 has four slaves and a
// short timeout of 8; instance u1 has a single slave for streaming.
module tb_bus_forkjoin_hub;
    import bus_hub_pkg::*;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_forkjoin_hub_if #(.NUM_SLAVES(4), .ADDR_W(8), .DATA_W(8)) bus0 ();
    bus_forkjoin_hub_if #(.NUM_SLAVES(1), .ADDR_W(8), .DATA_W(8)) bus1 ();

    bus_forkjoin_hub #(.NUM_SLAVES(4), .ADDR_W(8), .DATA_W(8), .TIMEOUT(8)) u0 (
        .clock (clk),
        .reset (rst),
        .bus   (bus0)
    );

    bus_forkjoin_hub #(.NUM_SLAVES(1), .ADDR_W(8), .DATA_W(8), .TIMEOUT(64)) u1 (
        .clock (clk),
        .reset (rst),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slaves(input logic [3:0] done, input logic [3:0] hit, input logic [31:0] rd);
        bus0.s_done  = done;
        bus0.s_hit   = hit;
        bus0.s_rdata = rd;
    endtask

    // Present a command in the current (idle) cycle and step into FORK.
    task automatic start_cmd(input logic w, input logic [7:0] a, input logic [7:0] d,
                             input string tag);
        bus0.m_req   = 1'b1;
        bus0.m_write = w;
        bus0.m_addr  = a;
        bus0.m_wdata = d;
        chk({tag, "_ready"}, 32'(bus0.m_ready), 32'd1);
        tick();
        bus0.m_req = 1'b0;
        chk({tag, "_sreq"}, 32'(bus0.s_req), 32'hF);
        chk({tag, "_saddr"}, 32'(bus0.s_addr), 32'(a));
        chk({tag, "_swrite"}, 32'(bus0.s_write), 32'(w));
    endtask

    initial begin
        rst = 1'b1;
        bus0.m_req = 0; bus0.m_write = 0; bus0.m_addr = 0; bus0.m_wdata = 0;
        bus0.s_done = 0; bus0.s_hit = 0; bus0.s_rdata = 0;
        bus1.m_req = 0; bus1.m_write = 0; bus1.m_addr = 0; bus1.m_wdata = 0;
        bus1.s_done = 0; bus1.s_hit = 0; bus1.s_rdata = 0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 32'(bus0.m_ready), 32'd1);
        chk("rst_sreq", 32'(bus0.s_req), 32'd0);
        chk("rst_rvalid", 32'(bus0.m_rvalid), 32'd0);
        chk("rst_err", 32'(bus0.m_err), 32'd0);
        chk("rst_rdata", 32'(bus0.m_rdata), 32'd0);
        chk("rst_saddr", 32'(bus0.s_addr), 32'd0);
        rst = 1'b0;

        // 1: read, all done at cycle 2, slave 2 hits with A5
        start_cmd(1'b0, 8'h3C, 8'h00, "t1");
        tick();
        slaves(4'hF, 4'b0100, 32'h33A51144);
        chk("t1_join_sreq", 32'(bus0.s_req), 32'd0);
        chk("t1_join_rvalid", 32'(bus0.m_rvalid), 32'd0);
        chk("t1_join_ready", 32'(bus0.m_ready), 32'd0);
        tick();
        slaves(4'h0, 4'h0, 32'h0);
        chk("t1_rvalid", 32'(bus0.m_rvalid), 32'd1);
        chk("t1_rdata", 32'(bus0.m_rdata), 32'hA5);
        chk("t1_err", 32'(bus0.m_err), 32'd0);
        tick();
        chk("t1_rvalid_off", 32'(bus0.m_rvalid), 32'd0);
        chk("t1_ready_back", 32'(bus0.m_ready), 32'd1);

        // 2: write, staggered done; last done lands on the final timer cycle
        start_cmd(1'b1, 8'h10, 8'h77, "t2");
        for (int c = 2; c <= 9; c++) begin
            tick();
            case (c)
                2: slaves(4'b0001, 4'b0001, 32'h00000055);
                3: slaves(4'b0001, 4'b0000, 32'h0);
                4: slaves(4'b0010, 4'b0000, 32'h0);
                5: slaves(4'b0100, 4'b0000, 32'h0);
                9: slaves(4'b1000, 4'b0000, 32'h0);
                default: slaves(4'h0, 4'h0, 32'h0);
            endcase
            chk("t2_wdata_hold", 32'(bus0.s_wdata), 32'h77);
            chk("t2_no_rvalid", 32'(bus0.m_rvalid), 32'd0);
        end
        tick();
        slaves(4'h0, 4'h0, 32'h0);
        chk("t2_rvalid", 32'(bus0.m_rvalid), 32'd1);
        chk("t2_err", 32'(bus0.m_err), 32'd0);
        chk("t2_rdata", 32'(bus0.m_rdata), 32'd0);
        chk("t2_wdata_resp", 32'(bus0.s_wdata), 32'h77);
        tick();

        // 3a: nobody claims -> DECERR
        start_cmd(1'b0, 8'h20, 8'h00, "t3a");
        tick();
        slaves(4'hF, 4'h0, 32'hDEADBEEF);
        tick();
        slaves(4'h0, 4'h0, 32'h0);
        chk("t3a_rvalid", 32'(bus0.m_rvalid), 32'd1);
        chk("t3a_err", 32'(bus0.m_err), 32'd1);
        chk("t3a_rdata", 32'(bus0.m_rdata), 32'd0);
        tick();

        // 3b: slaves 1 and 3 both claim -> MULTIHIT
        start_cmd(1'b0, 8'h21, 8'h00, "t3b");
        tick();
        slaves(4'hF, 4'b1010, 32'h33002200);
        tick();
        slaves(4'h0, 4'h0, 32'h0);
        chk("t3b_rvalid", 32'(bus0.m_rvalid), 32'd1);
        chk("t3b_err", 32'(bus0.m_err), 32'd2);
        chk("t3b_rdata", 32'(bus0.m_rdata), 32'd0);
        tick();

        // 4: slave 3 silent -> TIMEOUT 9 cycles after FORK
        start_cmd(1'b0, 8'h40, 8'h00, "t4");
        for (int c = 2; c <= 9; c++) begin
            tick();
            if (c == 2) slaves(4'b0111, 4'b0001, 32'h00000099);
            else        slaves(4'h0, 4'h0, 32'h0);
            chk("t4_no_rvalid", 32'(bus0.m_rvalid), 32'd0);
        end
        tick();
        chk("t4_rvalid", 32'(bus0.m_rvalid), 32'd1);
        chk("t4_err", 32'(bus0.m_err), 32'd3);
        chk("t4_rdata", 32'(bus0.m_rdata), 32'd0);
        tick();
        // Late claim from slave 3 while idle and during FORK must be ignored
        slaves(4'b1000, 4'b1000, 32'hEE000000);
        start_cmd(1'b0, 8'h41, 8'h00, "t4b");
        tick();
        slaves(4'hF, 4'b0010, 32'h00005A00);
        tick();
        slaves(4'h0, 4'h0, 32'h0);
        chk("t4b_rvalid", 32'(bus0.m_rvalid), 32'd1);
        chk("t4b_err", 32'(bus0.m_err), 32'd0);
        chk("t4b_rdata", 32'(bus0.m_rdata), 32'h5A);
        tick();

        // 5: reset in the middle of JOIN
        start_cmd(1'b0, 8'h50, 8'h00, "t5");
        tick();
        slaves(4'b0011, 4'h0, 32'h0);
        tick();
        slaves(4'h0, 4'h0, 32'h0);
        rst = 1'b1;
        #1;
        chk("t5_rst_sreq", 32'(bus0.s_req), 32'd0);
        chk("t5_rst_ready", 32'(bus0.m_ready), 32'd1);
        chk("t5_rst_rvalid", 32'(bus0.m_rvalid), 32'd0);
        chk("t5_rst_saddr", 32'(bus0.s_addr), 32'd0);
        tick();
        chk("t5_rst_ready2", 32'(bus0.m_ready), 32'd1);
        chk("t5_rst_rvalid2", 32'(bus0.m_rvalid), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t5_post_rvalid", 32'(bus0.m_rvalid), 32'd0);
            chk("t5_post_ready", 32'(bus0.m_ready), 32'd1);
            tick();
        end
        start_cmd(1'b0, 8'h51, 8'h00, "t5b");
        tick();
        slaves(4'hF, 4'b1000, 32'hC3000000);
        tick();
        slaves(4'h0, 4'h0, 32'h0);
        chk("t5b_rvalid", 32'(bus0.m_rvalid), 32'd1);
        chk("t5b_err", 32'(bus0.m_err), 32'd0);
        chk("t5b_rdata", 32'(bus0.m_rdata), 32'hC3);
        tick();

        // 6: single slave, request and done held high -> one response per 4 cycles
        bus1.m_write = 1'b0;
        bus1.m_addr  = 8'h07;
        bus1.s_done  = 1'b1;
        bus1.s_hit   = 1'b1;
        bus1.s_rdata = 8'h6E;
        bus1.m_req   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("t6_sreq", 32'(bus1.s_req), 32'(k % 4 == 1));
            chk("t6_rvalid", 32'(bus1.m_rvalid), 32'(k % 4 == 3));
            chk("t6_ready", 32'(bus1.m_ready), 32'(k % 4 == 0));
            if (k % 4 == 3) chk("t6_rdata", 32'(bus1.m_rdata), 32'h6E);
            tick();
        end
        bus1.m_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_forkjoin_hub.md
Name: bus_forkjoin_hub

Overview:
- Parametrised hardware fork/join dispatcher for the shared slave bus.
- Accepts one master command (read or write) at a time and broadcasts it to NUM_SLAVES slave ports in the same cycle (fork).
- Waits until every slave has reported completion (join), then returns one merged response to the master.
- Each slave reports whether it claimed the address. The hub checks for decode errors, multiple claims and timeout.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..32).
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- TIMEOUT, 64, max JOIN cycles before abort; 0 disables the timeout.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_req  in  1  master command valid.
- m_write  in  1  1 = write, 0 = read.
- m_addr  in  ADDR_W  command address.
- m_wdata  in  DATA_W  write data.
- m_ready  out  1  hub idle; command accepted when m_req && m_ready.
- m_rvalid  out  1  one-cycle response strobe.
- m_rdata  out  DATA_W  read data; valid only with m_rvalid.
- m_err  out  2  response code: 0 OK, 1 DECERR, 2 MULTIHIT, 3 TIMEOUT.
- s_req  out  NUM_SLAVES  per-slave fork pulse.
- s_write  out  1  latched command type.
- s_addr  out  ADDR_W  latched address.
- s_wdata  out  DATA_W  latched write data.
- s_done  in  NUM_SLAVES  per-slave completion pulse.
- s_hit  in  NUM_SLAVES  slave claimed the address; qualified by s_done.
- s_rdata  in  NUM_SLAVES*DATA_W  slave i read data at bits [i*DATA_W +: DATA_W]; qualified by s_done[i] && s_hit[i].

Behaviour:

Reset values:
- State IDLE; s_req = 0, m_rvalid = 0, m_rdata = 0, m_err = 0.
- s_write, s_addr, s_wdata = 0.
- done_mask, hit_mask, timer = 0.
- m_ready = (state == IDLE), so it is 1 while reset is held.

IDLE:
- m_ready = 1.
- On m_req: latch write/addr/wdata into the s_* registers, clear done_mask, hit_mask, captured data and timer, then go to FORK.

FORK (exactly 1 cycle):
- s_req = all ones; go to JOIN.

JOIN:
- s_req = 0; m_ready = 0.
- Each cycle: done_mask |= s_done; hit_mask |= s_done & s_hit.
- Capture rdata from the lowest-index slave with s_done && s_hit, on the first cycle any hit arrives. Later hits never overwrite it.
- A repeat s_done from a slave already marked done is ignored.
- timer increments each JOIN cycle.
- Exit to RESP when either:
  - done_mask (including this cycle's s_done) is all ones; or
  - TIMEOUT != 0 and timer == TIMEOUT-1 (timeout).
- If both exit conditions hold in the same cycle, completion wins.

RESP (exactly 1 cycle):
- m_rvalid = 1.
- m_err priority: TIMEOUT > MULTIHIT (popcount(hit_mask) > 1) > DECERR (hit_mask == 0) > OK.
- m_rdata = captured data only when m_err == OK and the command is a read; otherwise 0.
- Writes with OK return m_rdata = 0.
- Next state is IDLE.

Latency:
- Accept at cycle 0, s_req at cycle 1, earliest s_done sampled at cycle 2, m_rvalid at cycle 3.
- Back-to-back commands: the next accept can happen at cycle 4.

Other rules:
- s_done outside JOIN is ignored, including late responses after a timeout.
- s_write, s_addr and s_wdata hold stable from FORK through RESP.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs take reset values, and no m_rvalid is produced for the aborted command.
- Timer width is $clog2(TIMEOUT+1), minimum 1. Popcount is computed over NUM_SLAVES bits.

Decomposition:
- Package bus_hub_pkg holds:
  - typedef enum hub_state_e {IDLE, FORK, JOIN, RESP};
  - typedef enum logic [1:0] hub_err_e {ERR_OK, ERR_DECERR, ERR_MULTIHIT, ERR_TIMEOUT}.
- One sub-module, bus_join_tracker, owns:
  - the done/hit mask accumulation;
  - the lowest-index rdata capture;
  - the all_done, hit_count_gt1 and no_hit outputs.
  It has a clear input driven in IDLE. The hub top keeps the FSM, timer and master/slave registers.

Test Plan:
1. Read at 0x3C; all 4 slaves s_done at cycle 2, slave 2 hit with rdata 0xA5 -> m_rvalid at cycle 3, m_rdata = 0xA5, m_err = 0.
2. Write 0x10/0x77; slaves finish at cycles 2, 4, 5, 9 with slave 0 hit -> s_wdata held at 0x77 throughout, m_rvalid one cycle after slave 3's done, m_err = 0, m_rdata = 0.
3. Read where all slaves done with s_hit = 0 -> m_err = 1, m_rdata = 0. Read where slaves 1 and 3 both hit -> m_err = 2, m_rdata = 0.
4. TIMEOUT = 8, slave 3 never responds -> m_rvalid exactly 9 cycles after FORK with m_err = 3. A late s_done[3] in IDLE does not disturb the next command.
5. Reset asserted during JOIN -> s_req = 0, m_rvalid never pulses, m_ready = 1 during and after reset. A following read completes normally.
6. m_req held high continuously with NUM_SLAVES = 1 and immediate done -> responses every 4 cycles, each s_req a single-cycle pulse.
